uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters into one UART transmitter core.
// Supports a per-requester grant lock, a tx_busy watchdog and an optional idle gap after each frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GAP_CLKS = 0,
  parameter int BUSY_TMO = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = IDW + 1;
  localparam int TW  = $clog2(BUSY_TMO + 1);
  localparam int GW  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] last_grant, lock_owner, winner;
  logic           lock_active;
  logic           any_valid;
  logic [TW-1:0]  tmo_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           tmo_hit, gap_done;
  logic [SW-1:0]  rr_sum;
  logic [IDW-1:0] rr_cand;
  logic           rr_found;

  assign any_valid = |req_valid;
  assign tmo_hit   = (tmo_cnt == TW'(BUSY_TMO - 1)) && !tx_busy;
  assign gap_done  = (gap_cnt == GW'(GAP_CLKS - 1));

  // Scan upward from last_grant+1 with wraparound; a still-valid lock owner overrides the scan.
  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_grant} + SW'(k);
      if (rr_sum >= SW'(NUM_REQ)) rr_sum = rr_sum - SW'(NUM_REQ);
      rr_cand = rr_sum[IDW-1:0];
      if (!rr_found && req_valid[rr_cand]) begin
        winner   = rr_cand;
        rr_found = 1'b1;
      end
    end
    if (lock_active && req_valid[lock_owner]) winner = lock_owner;
  end

  always_comb begin
    state_nx  = state;
    tx_start  = 1'b0;
    req_ready = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:      if (any_valid) state_nx = LOAD;
      LOAD: begin
        tx_start            = 1'b1;
        req_ready[grant_id] = 1'b1;
        state_nx            = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)      state_nx = WAIT_DONE;
        else if (tmo_hit) state_nx = (GAP_CLKS == 0) ? IDLE : GAP;
      end
      WAIT_DONE: if (!tx_busy) state_nx = (GAP_CLKS == 0) ? IDLE : GAP;
      GAP:       if (gap_done) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= IDW'(NUM_REQ - 1);
      lock_active <= 1'b0;
      lock_owner  <= '0;
      err         <= 1'b0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (lock_active && !req_valid[lock_owner]) lock_active <= 1'b0;
          if (any_valid) begin
            tx_data     <= req_data[8*winner +: 8];
            grant_id    <= winner;
            last_grant  <= winner;
            lock_owner  <= winner;
            lock_active <= req_lock[winner];
          end
        end
        LOAD:      tmo_cnt <= '0;
        WAIT_BUSY: begin
          if (!tx_busy) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err <= 1'b1;
          end
        end
        WAIT_DONE: gap_cnt <= '0;
        GAP:       gap_cnt <= gap_cnt + 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: byte-queue requesters, a reactive transmitter model and
// a pick-order reference model; a second instance exercises the post-frame gap.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic [3:0]  req_valid, req_lock, req_ready;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, busy, err;
  logic [1:0]  grant_id;

  logic [3:0]  req_valid2, req_lock2, req_ready2;
  logic [31:0] req_data2;
  logic [7:0]  tx_data2;
  logic        tx_start2, tx_busy2, busy2, err2;
  logic [1:0]  grant_id2;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .BUSY_TMO(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .busy(busy), .err(err));

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(5), .BUSY_TMO(15)) dut_gap (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2), .req_lock(req_lock2),
    .req_ready(req_ready2), .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(tx_busy2),
    .grant_id(grant_id2), .busy(busy2), .err(err2));

  int total, bad;

  // Requester byte queues: each requester offers qdata[i][qhead[i]] until accepted.
  logic [7:0] qdata [4][8];
  bit         qlock [4][8];
  int         qhead [4];
  int         qlen  [4];
  int         ready_cnt [4];
  int         obs_g [32];

  // Reference arbitration state: last winner plus lock ownership.
  int m_last, m_owner;
  bit m_lock;

  bit xmit_en;
  int cfg_len, cfg_lat;

  function automatic void model_reset();
    m_last  = 3;
    m_owner = 0;
    m_lock  = 1'b0;
  endfunction

  function automatic int model_pick(input logic [3:0] v);
    if (m_lock && v[m_owner] === 1'b1) return m_owner;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (v[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic void model_commit(input int g, input logic lk);
    m_last  = g;
    m_owner = g;
    m_lock  = (lk === 1'b1);
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      if (qhead[i] < qlen[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qdata[i][qhead[i]];
        req_lock[i]        = qlock[i][qhead[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_lock[i]  = 1'b0;
      end
    end
  endtask

  // Transmitter core model: raises tx_busy some clocks after tx_start for a frame, aborts on reset.
  initial begin
    int lat, len;
    bit aborted;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (xmit_en && rst === 1'b0 && tx_start === 1'b1) begin
        lat     = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(3, 1));
        len     = (cfg_len > 0) ? cfg_len : int'($urandom_range(6, 1));
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst === 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          tx_busy = 1'b1;
          for (int i = 0; i < len && rst !== 1'b1; i++) @(negedge clk);
          tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      qhead[i] = 0;
      qlen[i]  = 0;
      ready_cnt[i] = 0;
    end
    drive_reqs();
    req_valid2 = '0;
    req_lock2  = '0;
    tx_busy2   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_start(output bit seen);
    int cnt;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (tx_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit seen);
    int cnt;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (busy === 1'b0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'hA1B2C3D4;
    repeat (2) @(negedge clk);
    total++;
    if (tx_start !== 1'b0 || req_ready !== 4'b0) begin
      bad++; $display("[TB] FAIL reset_pulses: tx_start=%b req_ready=%b, want 0/0000", tx_start, req_ready);
    end
    total++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
      bad++; $display("[TB] FAIL reset_regs: tx_data=%h grant_id=%0d, want 00/0", tx_data, grant_id);
    end
    total++;
    if (busy !== 1'b0 || err !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_flags: busy=%b err=%b busy2=%b, want 0/0/0", busy, err, busy2);
    end
    apply_reset();
  endtask

  task automatic test_single();
    bit seen;
    apply_reset();
    qlen[2] = 1;
    qdata[2][0] = 8'h5A;
    qlock[2][0] = 1'b0;
    drive_reqs();
    wait_start(seen);
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL single_start: got no tx_start, want one"); return;
    end
    total++;
    if (req_ready !== 4'b0100 || tx_data !== 8'h5A || grant_id !== 2'd2 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL single_load: ready=%b data=%h gid=%0d busy=%b, want 0100/5a/2/1",
                      req_ready, tx_data, grant_id, busy);
    end
    qhead[2]++;
    drive_reqs();
    @(negedge clk);
    total++;
    if (tx_start !== 1'b0 || req_ready !== 4'b0) begin
      bad++; $display("[TB] FAIL single_pulse: tx_start=%b req_ready=%b, want 0/0000", tx_start, req_ready);
    end
    wait_idle(seen);
    total++;
    if (!seen || tx_data !== 8'h5A) begin
      bad++; $display("[TB] FAIL single_hold: idle=%b tx_data=%h, want 1/5a", seen, tx_data);
    end
  endtask

  // Serves n grants, checking each against the reference pick and recording the observed order.
  task automatic test_grant_stream(input string name, input int n);
    bit seen;
    int g;
    for (int k = 0; k < n; k++) begin
      wait_start(seen);
      total++;
      if (!seen) begin
        bad++; $display("[TB] FAIL %s_start%0d: got no tx_start, want one", name, k); return;
      end
      g = model_pick(req_valid);
      obs_g[k] = int'(grant_id);
      total++;
      if (g < 0 || grant_id !== g[1:0]) begin
        bad++; $display("[TB] FAIL %s_grant%0d: grant_id=%0d, want %0d", name, k, grant_id, g);
      end
      if (g < 0) g = 0;
      total++;
      if (tx_data !== qdata[g][qhead[g]]) begin
        bad++; $display("[TB] FAIL %s_data%0d: tx_data=%h, want %h", name, k, tx_data, qdata[g][qhead[g]]);
      end
      total++;
      if (req_ready !== (4'b0001 << g)) begin
        bad++; $display("[TB] FAIL %s_ready%0d: req_ready=%b, want %b", name, k, req_ready, 4'b0001 << g);
      end
      for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) ready_cnt[i]++;
      model_commit(g, req_lock[g]);
      qhead[g]++;
      drive_reqs();
      @(negedge clk);
      total++;
      if (tx_start !== 1'b0 || req_ready !== 4'b0) begin
        bad++; $display("[TB] FAIL %s_pulse%0d: tx_start=%b req_ready=%b, want 0/0000", name, k, tx_start, req_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    cfg_len = 10;
    cfg_lat = 1;
    for (int i = 0; i < 4; i++) begin
      qlen[i] = 2;
      for (int j = 0; j < 2; j++) begin
        qdata[i][j] = 8'($urandom);
        qlock[i][j] = 1'b0;
      end
    end
    drive_reqs();
    test_grant_stream("rr", 8);
    wait_idle(seen);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (obs_g[k] != exp_order[k]) begin
        bad++; $display("[TB] FAIL rr_order%0d: grant=%0d, want %0d", k, obs_g[k], exp_order[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ready_cnt[i] != 2) begin
        bad++; $display("[TB] FAIL rr_count%0d: ready pulses=%0d, want 2", i, ready_cnt[i]);
      end
    end
    cfg_len = 0;
    cfg_lat = 0;
  endtask

  task automatic test_lock();
    bit seen;
    int exp_order [7] = '{0, 1, 1, 1, 2, 3, 0};
    apply_reset();
    qlen[0] = 2; qlen[1] = 3; qlen[2] = 1; qlen[3] = 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) begin
        qdata[i][j] = 8'($urandom);
        qlock[i][j] = (i == 1);
      end
    drive_reqs();
    test_grant_stream("lock", 7);
    wait_idle(seen);
    for (int k = 0; k < 7; k++) begin
      total++;
      if (obs_g[k] != exp_order[k]) begin
        bad++; $display("[TB] FAIL lock_order%0d: grant=%0d, want %0d", k, obs_g[k], exp_order[k]);
      end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    apply_reset();
    xmit_en = 1'b0;
    qlen[3] = 1;
    qdata[3][0] = 8'h3C;
    qlock[3][0] = 1'b0;
    drive_reqs();
    wait_start(seen);
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL tmo_start: got no tx_start, want one");
    end
    model_commit(3, 1'b0);
    qhead[3]++;
    drive_reqs();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("[TB] FAIL tmo_early: err=%b busy=%b at +15, want 0/1", err, busy);
        end
      end
      if (k == 16) begin
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
          bad++; $display("[TB] FAIL tmo_fire: err=%b busy=%b at +16, want 1/0", err, busy);
        end
      end
    end
    xmit_en = 1'b1;
    qlen[1] = 1;
    qdata[1][0] = 8'hE7;
    qlock[1][0] = 1'b0;
    drive_reqs();
    test_grant_stream("tmo_next", 1);
    wait_idle(seen);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("[TB] FAIL tmo_sticky: err=%b, want 1", err);
    end
  endtask

  task automatic test_gap();
    bit seen, extra;
    int cnt;
    apply_reset();
    req_data2  = 32'h000000C3;
    req_lock2  = 4'b0;
    req_valid2 = 4'b0001;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 50) begin
      @(negedge clk);
      cnt++;
      if (tx_start2 === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || req_ready2 !== 4'b0001 || tx_data2 !== 8'hC3) begin
      bad++; $display("[TB] FAIL gap_load: seen=%b ready=%b data=%h, want 1/0001/c3", seen, req_ready2, tx_data2);
    end
    req_valid2 = 4'b0;
    @(negedge clk);
    tx_busy2 = 1'b1;
    repeat (4) @(negedge clk);
    tx_busy2 = 1'b0;
    cnt   = 0;
    extra = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (tx_start2 === 1'b1) extra = 1'b1;
    end while (busy2 !== 1'b0 && cnt < 50);
    total++;
    if (cnt != 6) begin
      bad++; $display("[TB] FAIL gap_len: idle reached %0d clocks after busy fell, want 6", cnt);
    end
    total++;
    if (extra || err2 !== 1'b0) begin
      bad++; $display("[TB] FAIL gap_clean: extra_start=%b err=%b, want 0/0", extra, err2);
    end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    int cnt;
    apply_reset();
    cfg_len = 10;
    cfg_lat = 1;
    qlen[0] = 2; qlen[1] = 1; qlen[2] = 1; qlen[3] = 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) begin
        qdata[i][j] = 8'($urandom_range(255, 1));
        qlock[i][j] = 1'b0;
      end
    drive_reqs();
    test_grant_stream("mid_pre", 1);
    cnt = 0;
    while (tx_busy !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (tx_start !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_flags: start=%b ready=%b busy=%b err=%b, want all 0",
                      tx_start, req_ready, busy, err);
    end
    total++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
      bad++; $display("[TB] FAIL mid_regs: tx_data=%h grant_id=%0d, want 00/0", tx_data, grant_id);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    test_grant_stream("mid_post", 4);
    total++;
    if (obs_g[0] != 0) begin
      bad++; $display("[TB] FAIL mid_first: grant=%0d, want 0", obs_g[0]);
    end
    wait_idle(seen);
    cfg_len = 0;
    cfg_lat = 0;
  endtask

  task automatic test_random();
    int n;
    bit extra;
    for (int it = 0; it < 3; it++) begin
      apply_reset();
      n = 0;
      for (int i = 0; i < 4; i++) begin
        qlen[i] = (i == 0) ? int'($urandom_range(5, 1)) : int'($urandom_range(5, 0));
        n += qlen[i];
        for (int j = 0; j < qlen[i]; j++) begin
          qdata[i][j] = 8'($urandom);
          qlock[i][j] = 1'($urandom_range(1, 0));
        end
      end
      drive_reqs();
      test_grant_stream("rand", n);
      extra = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (tx_start === 1'b1) extra = 1'b1;
      end
      total++;
      if (extra || busy !== 1'b0 || req_valid !== 4'b0) begin
        bad++; $display("[TB] FAIL rand_drain%0d: extra_start=%b busy=%b pending=%b, want 0/0/0000",
                        it, extra, busy, req_valid);
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_lock   = '0;
    req_valid2 = '0;
    req_data2  = '0;
    req_lock2  = '0;
    tx_busy2   = 1'b0;
    xmit_en    = 1'b1;
    cfg_len    = 0;
    cfg_lat    = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_gap();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
